// File: rtl/fcs_pkg.sv
// Shared types and constants for the frame contrast stretch stage.
package fcs_pkg;

  localparam logic [15:0] GAIN_ONE = 16'h0100;
  localparam logic [15:0] GAIN_NUM = 16'd65280;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIV    = 2'd1,
    ST_COMMIT = 2'd2
  } div_state_t;

  function automatic logic [7:0] min8(input logic [7:0] a, input logic [7:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fcs_serial_div.sv
// 16-bit restoring divider, one quotient bit per cycle. done flags the final
// iteration; quotient holds the finished result from the following cycle on.
module fcs_serial_div (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [15:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient
);

  logic [15:0] rem_reg;
  logic [15:0] quo_reg;
  logic [15:0] dvs_reg;
  logic [3:0]  cnt_reg;
  logic [16:0] shifted;

  assign shifted  = {rem_reg, quo_reg[15]};
  assign done     = busy && (cnt_reg == 4'd15);
  assign quotient = quo_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_reg <= '0;
      quo_reg <= '0;
      dvs_reg <= '0;
      cnt_reg <= '0;
      busy    <= 1'b0;
    end else if (start) begin
      rem_reg <= '0;
      quo_reg <= dividend;
      dvs_reg <= divisor;
      cnt_reg <= '0;
      busy    <= 1'b1;
    end else if (busy) begin
      if (shifted >= {1'b0, dvs_reg}) begin
        rem_reg <= 16'(shifted - {1'b0, dvs_reg});
        quo_reg <= {quo_reg[14:0], 1'b1};
      end else begin
        rem_reg <= shifted[15:0];
        quo_reg <= {quo_reg[14:0], 1'b0};
      end
      cnt_reg <= cnt_reg + 4'd1;
      if (cnt_reg == 4'd15) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/frame_contrast_stretch.sv
// Frame-adaptive linear contrast stretch: min/max gathered over frame N set
// the gain/offset applied to frame N+1, with the gain divided out during vsync.
module frame_contrast_stretch
  import fcs_pkg::*;
#(
  parameter bit ENABLE    = 1'b1,
  parameter int MIN_RANGE = 16,
  parameter int PIC_WIDTH = 640
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pre_frame_vsync,
  input  logic        pre_frame_href,
  input  logic        pre_frame_clken,
  input  logic [23:0] pre_img,
  output logic        post_frame_vsync,
  output logic        post_frame_href,
  output logic        post_frame_clken,
  output logic [23:0] post_img,
  output logic        line_err
);

  localparam logic [8:0]  MIN_RANGE_W = 9'(MIN_RANGE);
  localparam logic [15:0] PIC_WIDTH_W = 16'(PIC_WIDTH);

  rgb888_t     pix;
  logic        vsync_q, href_q, vs_rise, href_fall;
  logic [7:0]  pix_min, pix_max, min_acc, max_acc, range_now, min_f;
  logic        small_range, skip_reg;
  logic [15:0] gain_reg, eff_gain, quotient, line_cnt;
  logic [7:0]  offset_reg, eff_off;
  logic        div_start, div_busy, div_done, commit;
  div_state_t  state_reg, state_next;
  logic [2:0]  vs_d, hr_d, ce_d;
  logic [23:0] raw_d1, raw_d2, stretched;

  assign pix         = pre_img;
  assign pix_min     = min8(min8(pix.r, pix.g), pix.b);
  assign pix_max     = max8(max8(pix.r, pix.g), pix.b);
  assign vs_rise     = pre_frame_vsync & ~vsync_q;
  assign href_fall   = href_q & ~pre_frame_href;
  assign range_now   = max_acc - min_acc;
  assign small_range = ({1'b0, range_now} < MIN_RANGE_W) || (range_now == 8'd0);
  assign eff_gain    = ENABLE ? gain_reg : GAIN_ONE;
  assign eff_off     = ENABLE ? offset_reg : 8'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q  <= 1'b0;
      href_q   <= 1'b0;
      min_acc  <= 8'hFF;
      max_acc  <= 8'h00;
      min_f    <= 8'h00;
      skip_reg <= 1'b1;
    end else begin
      vsync_q <= pre_frame_vsync;
      href_q  <= pre_frame_href;
      if (vs_rise) begin
        min_f    <= min_acc;
        skip_reg <= small_range;
        min_acc  <= 8'hFF;
        max_acc  <= 8'h00;
      end else if (pre_frame_clken) begin
        min_acc <= min8(min_acc, pix_min);
        max_acc <= max8(max_acc, pix_max);
      end
    end
  end

  fcs_serial_div u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (GAIN_NUM),
    .divisor  ({8'd0, range_now}),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (quotient)
  );

  // A new frame boundary always wins, restarting any division in flight.
  always_comb begin
    state_next = state_reg;
    div_start  = 1'b0;
    commit     = 1'b0;
    case (state_reg)
      ST_IDLE:   state_next = ST_IDLE;
      ST_DIV: begin
        if (div_done)       state_next = ST_COMMIT;
        else if (!div_busy) state_next = ST_IDLE;
      end
      ST_COMMIT: begin
        commit     = 1'b1;
        state_next = ST_IDLE;
      end
      default:   state_next = ST_IDLE;
    endcase
    if (vs_rise) begin
      div_start  = ~small_range;
      state_next = small_range ? ST_COMMIT : ST_DIV;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      gain_reg   <= GAIN_ONE;
      offset_reg <= 8'h00;
    end else begin
      state_reg <= state_next;
      if (commit) begin
        gain_reg   <= skip_reg ? GAIN_ONE : quotient;
        offset_reg <= skip_reg ? 8'h00 : min_f;
      end
    end
  end

  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_ch
    logic [8:0]  diff;
    logic [7:0]  d_reg;
    logic [23:0] p_reg;

    assign diff = {1'b0, pre_img[gi*8 +: 8]} - {1'b0, eff_off};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        d_reg <= '0;
        p_reg <= '0;
      end else begin
        d_reg <= diff[8] ? 8'd0 : diff[7:0];
        p_reg <= 24'(d_reg) * 24'(eff_gain);
      end
    end

    assign stretched[gi*8 +: 8] = (p_reg[23:16] != 8'd0) ? 8'hFF : p_reg[15:8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d     <= '0;
      hr_d     <= '0;
      ce_d     <= '0;
      raw_d1   <= '0;
      raw_d2   <= '0;
      post_img <= '0;
    end else begin
      vs_d   <= {vs_d[1:0], pre_frame_vsync};
      hr_d   <= {hr_d[1:0], pre_frame_href};
      ce_d   <= {ce_d[1:0], pre_frame_clken};
      raw_d1 <= pre_img;
      raw_d2 <= raw_d1;
      if (ENABLE) post_img <= ce_d[1] ? stretched : 24'h0;
      else        post_img <= raw_d2;
    end
  end

  assign post_frame_vsync = vs_d[2];
  assign post_frame_href  = hr_d[2];
  assign post_frame_clken = ce_d[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_cnt <= '0;
      line_err <= 1'b0;
    end else begin
      if (href_fall)                           line_cnt <= '0;
      else if (pre_frame_href && pre_frame_clken) line_cnt <= line_cnt + 16'd1;
      if (vs_rise)                                      line_err <= 1'b0;
      else if (href_fall && (line_cnt != PIC_WIDTH_W))  line_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_frame_contrast_stretch.sv
// Randomised bench for frame_contrast_stretch against a frame-level arithmetic model.
module tb_frame_contrast_stretch;
  import fcs_pkg::*;

  localparam int W       = 16;
  localparam int MINR    = 16;
  localparam int VS_HIGH = 24;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pre_frame_vsync = 1'b0;
  logic        pre_frame_href = 1'b0;
  logic        pre_frame_clken = 1'b0;
  logic [23:0] pre_img = 24'h0;
  logic        post_frame_vsync, post_frame_href, post_frame_clken, line_err;
  logic [23:0] post_img;

  int checks = 0;
  int errors = 0;

  logic [26:0] exp_q[$];
  logic [23:0] pix_q[$];
  logic [23:0] last_px = 24'h0;

  int m_gain = 256, m_off = 0, m_min = 255, m_max = 0, m_cnt = 0;
  bit m_prev_vs = 1'b0, m_prev_hr = 1'b0, m_err = 1'b0;

  frame_contrast_stretch #(.ENABLE(1'b1), .MIN_RANGE(MINR), .PIC_WIDTH(W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pre_frame_vsync  (pre_frame_vsync),
    .pre_frame_href   (pre_frame_href),
    .pre_frame_clken  (pre_frame_clken),
    .pre_img          (pre_img),
    .post_frame_vsync (post_frame_vsync),
    .post_frame_href  (post_frame_href),
    .post_frame_clken (post_frame_clken),
    .post_img         (post_img),
    .line_err         (line_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Gain/offset for the next frame from the previous frame's global extremes.
  task automatic frame_boundary();
    if (m_max >= m_min && (m_max - m_min) >= MINR) begin
      m_gain = 65280 / (m_max - m_min);
      m_off  = m_min;
    end else begin
      m_gain = 256;
      m_off  = 0;
    end
    m_min = 255;
    m_max = 0;
  endtask

  function automatic logic [23:0] model_px(input logic [23:0] px);
    logic [23:0] r;
    int c, d, o;
    r = 24'h0;
    for (int k = 0; k < 3; k++) begin
      c = int'((px >> (8 * k)) & 24'hFF);
      d = (c > m_off) ? c - m_off : 0;
      o = (d * m_gain) / 256;
      if (o > 255) o = 255;
      r[8*k +: 8] = 8'(o);
    end
    return r;
  endfunction

  task automatic tick(input bit vs, input bit hr, input bit ce, input logic [23:0] px);
    logic [26:0] got, exp;
    bit boundary;
    pre_frame_vsync = vs;
    pre_frame_href  = hr;
    pre_frame_clken = ce;
    pre_img         = px;
    boundary = vs && !m_prev_vs;
    if (boundary) begin
      frame_boundary();
      m_err = 1'b0;
    end else if (m_prev_hr && !hr && m_cnt != W) begin
      m_err = 1'b1;
    end
    if (m_prev_hr && !hr) m_cnt = 0;
    else if (hr && ce)    m_cnt++;
    exp_q.push_back({vs, hr, ce, ce ? model_px(px) : 24'h0});
    if (ce && !boundary) begin
      for (int k = 0; k < 3; k++) begin
        if (int'((px >> (8 * k)) & 24'hFF) < m_min) m_min = int'((px >> (8 * k)) & 24'hFF);
        if (int'((px >> (8 * k)) & 24'hFF) > m_max) m_max = int'((px >> (8 * k)) & 24'hFF);
      end
    end
    m_prev_vs = vs;
    m_prev_hr = hr;
    @(posedge clk);
    #1;
    if (exp_q.size() >= 3) begin
      got = {post_frame_vsync, post_frame_href, post_frame_clken, post_img};
      exp = exp_q.pop_front();
      chk("pix", 32'(got), 32'(exp));
    end
    chk("line_err", 32'(line_err), 32'(m_err));
  endtask

  task automatic vs_pulse();
    for (int i = 0; i < VS_HIGH; i++) tick(1'b1, 1'b0, 1'b0, 24'h0);
  endtask

  task automatic send_lines(input int short_line);
    int ln, n;
    logic [23:0] px;
    ln = 0;
    tick(1'b0, 1'b0, 1'b0, 24'h0);
    tick(1'b0, 1'b0, 1'b0, 24'h0);
    while (pix_q.size() > 0) begin
      n = (ln == short_line) ? W - 1 : W;
      for (int k = 0; k < n; k++) begin
        if (pix_q.size() > 0) px = pix_q.pop_front();
        else                  px = last_px;
        last_px = px;
        if ($urandom_range(0, 3) == 0) tick(1'b0, 1'b1, 1'b0, 24'h0);
        tick(1'b0, 1'b1, 1'b1, px);
      end
      tick(1'b0, 1'b0, 1'b0, 24'h0);
      tick(1'b0, 1'b0, 1'b0, 24'h0);
      ln++;
    end
  endtask

  function automatic logic [23:0] gray(input int v);
    return {8'(v), 8'(v), 8'(v)};
  endfunction

  task automatic fill_random(input int lo, input int hi, input int n);
    for (int i = 0; i < n; i++)
      pix_q.push_back({8'($urandom_range(lo, hi)), 8'($urandom_range(lo, hi)), 8'($urandom_range(lo, hi))});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_out", {4'h0, post_frame_vsync, post_frame_href, post_frame_clken, post_img, line_err}, 32'h0);
    chk("rst_state", 32'(dut.state_reg), 32'(ST_IDLE));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    m_gain = 256; m_off = 0; m_min = 255; m_max = 0; m_cnt = 0;
    m_prev_vs = 1'b0; m_prev_hr = 1'b0; m_err = 1'b0;
  endtask

  initial begin
    int lo;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", {4'h0, post_frame_vsync, post_frame_href, post_frame_clken, post_img, line_err}, 32'h0);
    chk("rst_gain", 32'(dut.gain_reg), 32'h0100);
    rst_n = 1'b1;

    // Frame 1: gray ramp 50..150, identity after reset
    vs_pulse();
    for (int i = 0; i < 32; i++) pix_q.push_back(gray(50 + (i * 100) / 31));
    send_lines(-1);

    // Frame 2: stretch from min 50, range 100
    vs_pulse();
    chk("ramp_gain", 32'(dut.gain_reg), 32'h028C);
    chk("ramp_off", 32'(dut.offset_reg), 32'd50);
    pix_q.push_back(gray(50));  pix_q.push_back(gray(100)); pix_q.push_back(gray(150));
    pix_q.push_back(gray(200)); pix_q.push_back(gray(20));
    fill_random(50, 150, 27);
    send_lines(-1);

    // Flat frame, then identity
    vs_pulse();
    for (int i = 0; i < 32; i++) pix_q.push_back(24'h808080);
    send_lines(-1);
    vs_pulse();
    chk("flat_gain", 32'(dut.gain_reg), 32'h0100);
    chk("flat_off", 32'(dut.offset_reg), 32'd0);

    // Range 10 -> identity; range 16 -> gain 0x0FF0
    pix_q.push_back(gray(100)); pix_q.push_back(gray(110));
    fill_random(100, 110, 30);
    send_lines(-1);
    vs_pulse();
    chk("r10_gain", 32'(dut.gain_reg), 32'h0100);
    pix_q.push_back(gray(100)); pix_q.push_back(gray(116));
    fill_random(100, 116, 30);
    send_lines(-1);
    vs_pulse();
    chk("r16_gain", 32'(dut.gain_reg), 32'h0FF0);
    pix_q.push_back(gray(101));
    fill_random(100, 116, 31);
    send_lines(-1);

    // Short line sets line_err, next vsync clears it
    vs_pulse();
    fill_random(0, 255, 32);
    send_lines(0);
    chk("short_err", 32'(line_err), 32'd1);
    vs_pulse();
    chk("err_clear", 32'(line_err), 32'd0);

    for (int f = 0; f < 6; f++) begin
      lo = $urandom_range(0, 200);
      fill_random(lo, lo + $urandom_range(0, 55), 32);
      send_lines(-1);
      vs_pulse();
    end

    // Reset in the middle of a division
    pix_q.push_back(gray(10)); pix_q.push_back(gray(200));
    fill_random(10, 200, 30);
    send_lines(-1);
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, 1'b0, 24'h0);
    chk("div_state", 32'(dut.state_reg), 32'(ST_DIV));
    do_reset();
    for (int i = 0; i < 20; i++) tick(1'b1, 1'b0, 1'b0, 24'h0);
    chk("post_rst_gain", 32'(dut.gain_reg), 32'h0100);
    chk("post_rst_state", 32'(dut.state_reg), 32'(ST_IDLE));
    fill_random(0, 255, 32);
    send_lines(-1);
    vs_pulse();
    fill_random(30, 180, 32);
    send_lines(-1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
